// File: rtl/hw_accel_pkg.sv
// hw_accel_pkg: shared sizing constants and helpers for the hw_accel output path.
package hw_accel_pkg;
  localparam int DEF_IMG_WIDTH = 512;
  localparam int DEF_IMG_HEIGHT = 512;
  localparam int DEF_PIX_PER_WORD = 4;
  localparam int TOTAL_PIX = DEF_IMG_WIDTH * DEF_IMG_HEIGHT;
  localparam int PIX_CNT_W = $clog2(TOTAL_PIX + 1);
  localparam int LANE_W = $clog2(DEF_PIX_PER_WORD);
  function automatic int total_pix(int w, int h);
    return w * h;
  endfunction
  function automatic int pix_cnt_w(int total);
    return $clog2(total + 1);
  endfunction
  function automatic int lane_w(int ppw);
    return $clog2(ppw);
  endfunction
endpackage

// File: rtl/hw_accel_sync_fifo.sv
// hw_accel_sync_fifo: show-ahead synchronous FIFO; a push into a full FIFO is
// taken only when a pop frees a slot in the same cycle, otherwise it is dropped.
module hw_accel_sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_drop
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic w_full, w_wr, w_rd;
  always_comb begin
    o_valid = r_cnt != '0;
    w_full = r_cnt == (AW+1)'(DEPTH);
    w_rd = i_pop && o_valid;
    w_wr = i_push && (!w_full || w_rd);
    o_drop = i_push && !w_wr;
    o_data = o_valid ? r_mem[r_rp] : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      r_wp <= r_wp + AW'(w_wr);
      r_rp <= r_rp + AW'(w_rd);
      r_cnt <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_rd);
    end
  end
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp] <= i_data;
  end
endmodule

// File: rtl/hw_accel_out_packer.sv
// hw_accel_out_packer: packs the unstallable pixel stream into wide words,
// tags the frame's last word and buffers words for a valid/ready sink.
module hw_accel_out_packer
  import hw_accel_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int PIX_PER_WORD = DEF_PIX_PER_WORD,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      frame_start,
  input  logic [DATA_WIDTH-1:0]                     pixel_in,
  input  logic                                      pixel_in_valid,
  output logic [DATA_WIDTH*PIX_PER_WORD-1:0]        word_out,
  output logic                                      word_out_valid,
  input  logic                                      word_out_ready,
  output logic                                      word_out_last,
  output logic                                      frame_done,
  output logic                                      overflow,
  output logic [$clog2(IMG_WIDTH*IMG_HEIGHT+1)-1:0] pixel_count
);
  localparam int TOTAL = total_pix(IMG_WIDTH, IMG_HEIGHT);
  localparam int CW = pix_cnt_w(TOTAL);
  localparam int LW = lane_w(PIX_PER_WORD);
  localparam int WW = DATA_WIDTH * PIX_PER_WORD;
  logic [CW-1:0] r_cnt, w_cnt_base, w_cnt_next;
  logic [LW-1:0] r_lane, w_lane_base;
  logic [WW-1:0] r_acc, w_acc_base, w_acc_next, r_pack_word;
  logic r_pack_v, r_pack_last, r_ovf, r_done;
  logic w_accept, w_last, w_close, w_drop, w_valid;
  logic [WW:0] w_head;
  // frame_start restarts counting in the same cycle so a coincident pixel becomes pixel 0
  always_comb begin
    w_cnt_base = frame_start ? '0 : r_cnt;
    w_lane_base = frame_start ? '0 : r_lane;
    w_acc_base = frame_start ? '0 : r_acc;
    w_accept = pixel_in_valid && (w_cnt_base != CW'(TOTAL));
    w_cnt_next = w_cnt_base + CW'(w_accept);
    w_acc_next = w_acc_base | (WW'(pixel_in) << (w_lane_base * DATA_WIDTH));
    w_last = w_cnt_next == CW'(TOTAL);
    w_close = w_accept && (w_lane_base == LW'(PIX_PER_WORD - 1) || w_last);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_lane <= '0;
      r_acc <= '0;
      r_pack_v <= 1'b0;
      r_pack_word <= '0;
      r_pack_last <= 1'b0;
      r_ovf <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_cnt <= w_cnt_next;
      r_lane <= w_close ? '0 : w_lane_base + LW'(w_accept);
      r_acc <= w_close ? '0 : (w_accept ? w_acc_next : w_acc_base);
      r_pack_v <= w_close;
      if (w_close) begin
        r_pack_word <= w_acc_next;
        r_pack_last <= w_last;
      end
      r_ovf <= !frame_start && (r_ovf || w_drop);
      r_done <= w_valid && word_out_ready && w_head[WW];
    end
  end
  hw_accel_sync_fifo #(
    .WIDTH(WW + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk(clk),
    .rst(rst),
    .i_push(r_pack_v),
    .i_pop(word_out_ready),
    .i_data({r_pack_last, r_pack_word}),
    .o_data(w_head),
    .o_valid(w_valid),
    .o_drop(w_drop)
  );
  assign word_out = w_head[WW-1:0];
  assign word_out_last = w_head[WW];
  assign word_out_valid = w_valid;
  assign frame_done = r_done;
  assign overflow = r_ovf;
  assign pixel_count = r_cnt;
endmodule

// File: tb/tb_hw_accel_out_packer.sv
// tb_hw_accel_out_packer: randomized and directed stimulus against a queue-based
// reference model, with a scoreboard monitor on the output stream.
module tb_hw_accel_out_packer;
  localparam int DW = 8, IW = 7, IH = 3, PPW = 4, DEPTH = 4;
  localparam int TOTAL = IW * IH, WW = DW * PPW, CW = $clog2(TOTAL + 1);
  typedef struct {logic last; logic [WW-1:0] word;} exp_t;
  logic clk = 0, rst = 1, frame_start = 0, pixel_in_valid = 0, word_out_ready = 0;
  logic [DW-1:0] pixel_in = 0;
  logic [WW-1:0] word_out;
  logic word_out_valid, word_out_last, frame_done, overflow;
  logic [CW-1:0] pixel_count;
  int n_chk = 0, n_fail = 0, cyc = 0, t4 = -1, first_valid = -1, done_cnt = 0;
  int m_cnt = 0, m_occ = 0;
  int m_pix[$];
  exp_t sb[$];
  exp_t m_pend_w;
  logic m_ovf = 0, m_pend = 0, exp_done = 0;

  always #5 clk = ~clk;

  hw_accel_out_packer #(
    .DATA_WIDTH(DW), .IMG_WIDTH(IW), .IMG_HEIGHT(IH),
    .PIX_PER_WORD(PPW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .pixel_in(pixel_in),
    .pixel_in_valid(pixel_in_valid), .word_out(word_out), .word_out_valid(word_out_valid),
    .word_out_ready(word_out_ready), .word_out_last(word_out_last), .frame_done(frame_done),
    .overflow(overflow), .pixel_count(pixel_count)
  );

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // reference model: inputs seen at a negedge act on the following posedge
  always @(negedge clk) begin : model
    logic pop, drop;
    if (rst) begin
      m_cnt = 0; m_occ = 0; m_ovf = 0; m_pend = 0;
      m_pix.delete(); sb.delete();
    end else begin
      chk("pixel_count", pixel_count, m_cnt);
      chk("overflow", overflow, m_ovf);
      pop = m_occ > 0 && word_out_ready;
      drop = m_pend && m_occ == DEPTH && !pop;
      if (pop) m_occ--;
      if (m_pend && !drop) begin
        m_occ++;
        sb.push_back(m_pend_w);
      end
      if (frame_start) m_ovf = 0;
      else if (drop) m_ovf = 1;
      m_pend = 0;
      if (frame_start) begin
        m_cnt = 0;
        m_pix.delete();
      end
      if (pixel_in_valid && m_cnt < TOTAL) begin
        m_pix.push_back(int'(pixel_in));
        m_cnt++;
        if (m_pix.size() == PPW || m_cnt == TOTAL) begin
          m_pend_w.word = '0;
          foreach (m_pix[k]) m_pend_w.word = m_pend_w.word | (WW'(m_pix[k]) << (DW * k));
          m_pend_w.last = (m_cnt == TOTAL);
          m_pend = 1;
          m_pix.delete();
        end
      end
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) exp_done = 0;
    else begin
      chk("frame_done", frame_done, exp_done);
      if (frame_done) done_cnt++;
      exp_done = 0;
      if (word_out_valid && first_valid < 0) first_valid = cyc;
      if (word_out_valid && word_out_ready) begin
        if (sb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_word: got %h expected none", word_out);
        end else begin
          e = sb.pop_front();
          chk("word_out", word_out, e.word);
          chk("word_out_last", word_out_last, e.last);
          exp_done = e.last;
        end
      end
    end
  end

  task automatic step(input logic v, input int p, input logic fs);
    @(posedge clk); #1;
    pixel_in_valid = v; pixel_in = DW'(p); frame_start = fs;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, word_out_valid, 0);
    chk({tag, "_word"}, word_out, 0);
    chk({tag, "_last"}, word_out_last, 0);
    chk({tag, "_done"}, frame_done, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_count"}, pixel_count, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 0;
    word_out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      step(1, i, 0);
      if (i == 4) t4 = cyc;
    end
    idle(6);
    chk("latency", first_valid - t4, 2);
    for (int i = 0; i < TOTAL; i++) step(1, 'h11 + i, i == 0);
    idle(8);
    chk("t2_count", pixel_count, TOTAL);
    chk("t2_done_seen", done_cnt, 1);
    word_out_ready = 0;
    for (int i = 0; i < 20; i++) step(1, 'h40 + i, i == 0);
    idle(4);
    chk("t3_overflow_set", overflow, 1);
    step(0, 0, 1);
    idle(1);
    chk("t3_overflow_clr", overflow, 0);
    word_out_ready = 1;
    idle(8);
    chk("t3_drained", sb.size(), 0);
    word_out_ready = 0;
    for (int i = 0; i < 20; i++) step(1, 'h60 + i, i == 0);
    step(0, 0, 0);
    word_out_ready = 1;
    step(0, 0, 0);
    word_out_ready = 0;
    idle(3);
    chk("t4_overflow", overflow, 0);
    word_out_ready = 1;
    idle(8);
    chk("t4_drained", sb.size(), 0);
    step(1, 1, 1); step(1, 2, 0); step(1, 3, 0);
    step(1, 'hAA, 1);
    step(1, 'hBB, 0);
    chk("t5_count", pixel_count, 1);
    step(1, 'hCC, 0); step(1, 'hDD, 0);
    idle(6);
    word_out_ready = 0;
    for (int i = 0; i < TOTAL + 5; i++) step(1, int'($urandom_range(0, 255)), i == 0);
    idle(4);
    chk("t6_count_sat", pixel_count, TOTAL);
    step(1, 'h5A, 1); step(1, 'h5B, 0); step(0, 0, 0);
    chk("t6_pre_valid", word_out_valid, 1);
    chk("t6_pre_count", pixel_count, 2);
    #1 rst = 1;
    #1 chk_zero("async_rst");
    idle(2);
    rst = 0;
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 9) < 7, int'($urandom_range(0, 255)), $urandom_range(0, 49) == 0);
      word_out_ready = $urandom_range(0, 9) < 6;
    end
    step(0, 0, 0);
    word_out_ready = 1;
    idle(12);
    chk("final_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
